// File: rtl/uart_rom_loader.sv
// Boot loader: UART 8N1 receiver feeding a frame parser that writes 32-bit words
// into the instruction ROM and releases the CPU once the checksum matches.
module uart_rom_loader #(
  parameter int WAIT   = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);
  localparam int CW = $clog2(WAIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(WAIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(WAIT - 1);
  localparam logic [16:0]   CAP     = 17'(2**ADDR_W);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [2:0] {L_CNT_LO, L_CNT_HI, L_DATA, L_CHECK, L_DONE, L_ERR} ld_state_e;

  // ---------------- receiver ----------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_vld, frame_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      R_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = R_START;
        rx_cnt_d   = HALF_M1;
      end
      R_START: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        // a start bit that is high again at mid-bit was a glitch
        else if (!rx_sync_q) begin
          rx_state_d = R_DATA;
          rx_cnt_d   = FULL_M1;
          rx_bit_d   = '0;
        end else rx_state_d = R_IDLE;
      end
      R_DATA: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = FULL_M1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          byte_vld   = rx_sync_q;
          frame_err  = !rx_sync_q;
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_e         state_q, state_d;
  logic [7:0]        n_lo_q, n_lo_d;
  logic [15:0]       n_q, n_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic [15:0]       n_new;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= L_CNT_LO;
      n_lo_q      <= '0;
      n_q         <= '0;
      asm_q       <= '0;
      byte_idx_q  <= '0;
      word_cnt_q  <= '0;
      xor_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      n_lo_q      <= n_lo_d;
      n_q         <= n_d;
      asm_q       <= asm_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      xor_q       <= xor_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_lo_d      = n_lo_q;
    n_d         = n_q;
    asm_d       = asm_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    xor_d       = xor_q;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;
    n_new       = {rx_shift_q, n_lo_q};
    if (frame_err && state_q != L_DONE && state_q != L_ERR) begin
      state_d = L_ERR;
    end else if (byte_vld) begin
      case (state_q)
        L_CNT_LO: begin
          n_lo_d  = rx_shift_q;
          xor_d   = xor_q ^ rx_shift_q;
          state_d = L_CNT_HI;
        end
        L_CNT_HI: begin
          n_d   = n_new;
          xor_d = xor_q ^ rx_shift_q;
          if ({1'b0, n_new} > CAP) state_d = L_ERR;
          else if (n_new == '0)    state_d = L_CHECK;
          else                     state_d = L_DATA;
        end
        L_DATA: begin
          xor_d      = xor_q ^ rx_shift_q;
          byte_idx_d = byte_idx_q + 2'd1;
          // bytes enter at the top so the first one ends up in bits 7:0
          if (byte_idx_q == 2'd3) begin
            rom_we_d    = 1'b1;
            rom_wdata_d = {rx_shift_q, asm_q};
            rom_waddr_d = word_cnt_q[ADDR_W-1:0];
            word_cnt_d  = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == n_q) state_d = L_CHECK;
          end else begin
            asm_d = {rx_shift_q, asm_q[23:8]};
          end
        end
        L_CHECK: state_d = (rx_shift_q == xor_q) ? L_DONE : L_ERR;
        default: ;
      endcase
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_waddr = rom_waddr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = (state_q != L_DONE);
  assign load_done = (state_q == L_DONE);
  assign load_err  = (state_q == L_ERR);
endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: directed bring-up scenarios plus random frames
// checked against a byte-level frame model.
module tb_uart_rom_loader;
  localparam int WAIT = 8;

  logic        clk = 1'b0, reset_n = 1'b0, rx = 1'b1, rx2 = 1'b1;
  logic        rom_we, cpu_reset, load_done, load_err;
  logic [7:0]  rom_waddr;
  logic [31:0] rom_wdata;
  logic        rom_we2, cpu_reset2, load_done2, load_err2;
  logic [1:0]  rom_waddr2;
  logic [31:0] rom_wdata2;

  always #5 clk = ~clk;

  uart_rom_loader #(.WAIT(WAIT), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx), .rom_we(rom_we),
    .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_err(load_err));

  uart_rom_loader #(.WAIT(WAIT), .ADDR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx2), .rom_we(rom_we2),
    .rom_waddr(rom_waddr2), .rom_wdata(rom_wdata2), .cpu_reset(cpu_reset2),
    .load_done(load_done2), .load_err(load_err2));

  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  errors = 0, checks = 0;

  always @(negedge clk) if (rom_we) got_q.push_back('{rom_waddr, rom_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx = 1'b1; rx2 = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_line(input bit sel2, input logic v);
    if (sel2) rx2 = v; else rx = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit sel2);
    set_line(sel2, 1'b0);
    repeat (WAIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel2, b[i]);
      repeat (WAIT) @(negedge clk);
    end
    set_line(sel2, stop_ok);
    repeat (WAIT) @(negedge clk);
    set_line(sel2, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit sel2);
    foreach (f[i]) send_byte(f[i], 1'b1, sel2);
    repeat (4) @(negedge clk);
  endtask

  // Interprets a byte stream as a frame: count, words, checksum.
  task automatic model(input logic [7:0] f[$], input int cap, output bit done, output bit err);
    int n; logic [7:0] x;
    done = 0; err = 0;
    exp_q.delete();
    if (f.size() < 2) return;
    n = int'(f[0]) + 256 * int'(f[1]);
    if (n > cap) begin err = 1; return; end
    for (int w = 0; w < n; w++) begin
      if (f.size() < 2 + 4*w + 4) return;
      exp_q.push_back('{8'(w), {f[2+4*w+3], f[2+4*w+2], f[2+4*w+1], f[2+4*w]}});
    end
    if (f.size() < 2 + 4*n + 1) return;
    x = 8'h00;
    for (int i = 0; i < 2 + 4*n; i++) x ^= f[i];
    if (x == f[2 + 4*n]) done = 1; else err = 1;
  endtask

  task automatic verify(input string tag, input bit done, input bit err);
    check({tag, "/nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s/addr%0d", tag, i), {24'h0, got_q[i].addr}, {24'h0, exp_q[i].addr});
      check($sformatf("%s/data%0d", tag, i), got_q[i].data, exp_q[i].data);
    end
    check({tag, "/done"}, load_done, done);
    check({tag, "/err"}, load_err, err);
    check({tag, "/cpu_reset"}, cpu_reset, !done);
  endtask

  initial begin
    logic [7:0] f[$];
    bit d, e;

    // reset values
    #2;
    check("rst/we", rom_we, 0);
    check("rst/waddr", rom_waddr, 0);
    check("rst/wdata", rom_wdata, 0);
    check("rst/cpu_reset", cpu_reset, 1);
    check("rst/done", load_done, 0);
    check("rst/err", load_err, 0);
    do_reset();

    // single word
    f = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h30, 8'h00};
    send_frame(f, 0);
    check("one/held_before_csum", cpu_reset, 1);
    f = '{8'h33};
    send_frame(f, 0);
    exp_q.push_back('{8'h00, 32'h00300200});
    verify("one", 1, 0);

    // two words
    do_reset();
    f = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h30, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h3A};
    send_frame(f, 0);
    exp_q.push_back('{8'h00, 32'h00300200});
    exp_q.push_back('{8'h01, 32'h0000000A});
    verify("two", 1, 0);

    // bad checksum, then further traffic is ignored
    do_reset();
    f = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h30, 8'h00, 8'h34};
    send_frame(f, 0);
    exp_q.push_back('{8'h00, 32'h00300200});
    verify("badcsum", 0, 1);
    f = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(f, 0);
    verify("after_err", 0, 1);

    // empty program
    do_reset();
    f = '{8'h00, 8'h00, 8'h00};
    send_frame(f, 0);
    verify("empty", 1, 0);

    // capacity limits on a 4-word ROM
    do_reset();
    f = '{8'h05, 8'h00};
    send_frame(f, 1);
    check("cap/over_err", load_err2, 1);
    check("cap/over_cpu", cpu_reset2, 1);
    do_reset();
    f = '{8'h04, 8'h00};
    for (int i = 0; i < 16; i++) f.push_back(8'(i * 7 + 1));
    begin
      logic [7:0] x = 8'h00;
      foreach (f[i]) x ^= f[i];
      f.push_back(x);
    end
    send_frame(f, 1);
    check("cap/full_done", load_done2, 1);
    check("cap/full_err", load_err2, 0);

    // framing error mid-word
    do_reset();
    f = '{8'h01, 8'h00, 8'h00};
    send_frame(f, 0);
    send_byte(8'h02, 1'b0, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    verify("framing", 0, 1);

    // glitch while idle must not register as a byte
    do_reset();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch/err", load_err, 0);
    check("glitch/done", load_done, 0);
    f = '{8'h00, 8'h00, 8'h00};
    send_frame(f, 0);
    verify("glitch_then_empty", 1, 0);

    // async reset partway through a word
    do_reset();
    f = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h30};
    send_frame(f, 0);
    #3 reset_n = 1'b0;
    #1;
    check("midrst/cpu_reset", cpu_reset, 1);
    check("midrst/we", rom_we, 0);
    check("midrst/waddr", rom_waddr, 0);
    check("midrst/wdata", rom_wdata, 0);
    check("midrst/err", load_err, 0);
    do_reset();
    f = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h30, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h3A};
    send_frame(f, 0);
    exp_q.push_back('{8'h00, 32'h00300200});
    exp_q.push_back('{8'h01, 32'h0000000A});
    verify("midrst_two", 1, 0);

    // random frames against the model
    for (int t = 0; t < 6; t++) begin
      int n;
      logic [7:0] x;
      do_reset();
      n = $urandom_range(0, 5);
      f = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
      x = 8'h00;
      foreach (f[i]) x ^= f[i];
      if ($urandom_range(0, 2) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      f.push_back(x);
      send_frame(f, 0);
      model(f, 256, d, e);
      verify($sformatf("rand%0d", t), d, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
